regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port of the RV32I core between two writeback requesters: requester 0 is the ALU/branch-link path and requester 1 is the load unit.
- Arbitrates between them round-robin and accepts at most one write per cycle.
- Drives a registered one-hot write-enable vector, one bit per 32-bit register-enable cell, plus the shared write data.
- Sits between the execute/memory stages and the register bank.

Parameters:
DATA_W, 32, width of write data and of each register cell
ADDR_W, 5, destination register index width
NUM_REGS, 32, number of registers; must equal 2**ADDR_W

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
hold  input  1  when 1, no request is granted this cycle
req0_valid  input  1  requester 0 has a write pending
req0_rd  input  ADDR_W  requester 0 destination index
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 granted this cycle (combinational)
req1_valid  input  1  requester 1 has a write pending
req1_rd  input  ADDR_W  requester 1 destination index
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 granted this cycle (combinational)
we_vec  output  NUM_REGS  one-hot write enables to the register cells (registered)
wr_data  output  DATA_W  shared write data to all cells (registered)
wr_addr  output  ADDR_W  index written, for debug and forwarding (registered)
wr_valid  output  1  a granted write is being presented this cycle (registered)
grant_cnt  output  16  total accepted writes, wraps at 65535 -> 0 (registered)

Behaviour:
- Only clock and reset exist: one clock. reset is synchronous and active-high. It is sampled on the rising edge of clock and takes priority over all other activity.
- Reset values: we_vec=0, wr_data=0, wr_addr=0, wr_valid=0, grant_cnt=0, rr pointer=0 (requester 0 preferred).
- A transfer on requester k occurs in any cycle where reqk_valid=1 and reqk_ready=1.
- Requesters must hold valid, rd and data stable until they are accepted.
- Grant logic (combinational):
  - hold=1 or reset=1 -> both readys 0.
  - Else, only one valid -> that requester is granted.
  - Else, both valid -> the requester selected by rr pointer is granted.
  - Else -> none granted.
- Ready never depends on the arbiter's own outputs, so there is no combinational loop.
- rr pointer update: it changes only on a contended grant (both valid, not held). It then points to the requester that was not granted. Uncontested grants leave it unchanged.
- Latency: a transfer accepted at edge N is presented on the outputs for exactly the cycle after edge N. wr_valid=1, wr_addr=rd and wr_data=data for that one cycle.
- Throughput is one write per cycle, back-to-back, with no bubbles.
- we_vec: bit rd is 1 during the presentation cycle. All bits are 0 in any cycle with no transfer.
- At most one bit of we_vec is ever set.
- x0 rule: a transfer with rd=0 is accepted and counted in grant_cnt, and wr_valid=1 and wr_addr=0. we_vec stays all-zero, so x0 is never written.
- wr_data and wr_addr hold their last values when wr_valid=0. Only we_vec and wr_valid clear.
- grant_cnt increments by 1 per transfer, including rd=0 transfers. It wraps 0xFFFF -> 0x0000.
- Reset mid-operation: a write already registered is discarded (we_vec cleared on that edge). No request is accepted in the reset cycle, and requesters keep their valids up.
- hold asserted while a write is being presented does not cancel that presentation. hold only blocks new grants.

Test Plan:
- Reset then idle: assert reset 2 cycles, then no valids for 5 cycles -> all outputs 0, readys 0, grant_cnt=0.
- Single write: req0 rd=5 data=0xDEADBEEF for 1 cycle -> req0_ready=1 same cycle. Next cycle we_vec=0x00000020, wr_data=0xDEADBEEF, wr_valid=1. Following cycle we_vec=0, grant_cnt=1.
- Contention round-robin: both valid continuously, req0 rd=1/0x11, req1 rd=2/0x22, over 4 cycles -> grants alternate 0,1,0,1; we_vec sequence 0x2,0x4,0x2,0x4; grant_cnt=4.
- x0 suppression: req1 rd=0 data=0xFFFFFFFF -> accepted, wr_valid=1, wr_addr=0, we_vec=0, grant_cnt increments.
- hold and mid-reset: hold=1 with both valid for 3 cycles -> no readys. Release hold and accept req0 rd=7, assert reset on the next edge -> we_vec=0 after that edge, grant_cnt=0, rr pointer back to requester 0.
- Counter wrap: force 65536 accepted writes -> grant_cnt returns to 0x0000.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register bank.
// The arbiter takes the slave view; requesters/bank (or a bench) take the master view.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
);
    logic                hold;

    logic                req0_valid;
    logic [ADDR_W-1:0]   req0_rd;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;

    logic                req1_valid;
    logic [ADDR_W-1:0]   req1_rd;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;

    logic [NUM_REGS-1:0] we_vec;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_valid;
    logic [15:0]         grant_cnt;

    modport slave (
        input  hold,
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        output we_vec, wr_data, wr_addr, wr_valid, grant_cnt
    );

    modport master (
        output hold,
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        input  we_vec, wr_data, wr_addr, wr_valid, grant_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU path (req0)
// and the load unit (req1); presents one registered one-hot write per cycle.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input logic                 clock,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);

    typedef enum logic [0:0] {PrefReq0, PrefReq1} rr_e;

    rr_e                 rr_q, rr_d;
    logic                grant0, grant1, xfer;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;

    logic [NUM_REGS-1:0] we_vec_q, we_vec_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wr_valid_q, wr_valid_d;
    logic [15:0]         grant_cnt_q, grant_cnt_d;

    // Grants depend only on inputs and the rr pointer, never on the write outputs.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        rr_d   = rr_q;
        if (!reset && !bus.hold) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (rr_q == PrefReq0) begin
                    grant0 = 1'b1;
                    rr_d   = PrefReq1;
                end else begin
                    grant1 = 1'b1;
                    rr_d   = PrefReq0;
                end
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        xfer        = grant0 | grant1;
        sel_rd      = grant1 ? bus.req1_rd   : bus.req0_rd;
        sel_data    = grant1 ? bus.req1_data : bus.req0_data;
        we_vec_d    = '0;
        wr_valid_d  = xfer;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_cnt_d = grant_cnt_q;
        if (xfer) begin
            wr_addr_d   = sel_rd;
            wr_data_d   = sel_data;
            grant_cnt_d = grant_cnt_q + 16'd1;
            // x0 is hardwired zero: the write is accepted and counted but never enabled.
            if (sel_rd != '0) begin
                we_vec_d[sel_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q        <= PrefReq0;
            we_vec_q    <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            wr_valid_q  <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            rr_q        <= rr_d;
            we_vec_q    <= we_vec_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_valid_q  <= wr_valid_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.we_vec     = we_vec_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.grant_cnt  = grant_cnt_q;

    a_we_onehot0: assert property (@(posedge clock) $onehot0(we_vec_q));
    a_single_grant: assert property (@(posedge clock) !(grant0 && grant1));
    a_we_needs_valid: assert property (@(posedge clock) wr_valid_q || (we_vec_q == '0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected writes into a
// scoreboard queue, a monitor pops and compares whenever wr_valid is presented.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] we;
        logic [15:0] cnt;
    } exp_t;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  sb[$];
    logic [15:0] exp_cnt = 16'd0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.rd   = rd;
        e.data = data;
        e.we   = (rd == 5'd0) ? 32'd0 : (32'd1 << rd);
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic rst, input logic hld,
                         input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                         input logic er0, input logic er1);
        reset          = rst;
        bus.hold       = hld;
        bus.req0_valid = v0;
        bus.req0_rd    = rd0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_rd    = rd1;
        bus.req1_data  = d1;
        @(negedge clock);
        check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, er0});
        check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, er1});
        if (er0) push(rd0, d0);
        else if (er1) push(rd1, d1);
        if (rst) exp_cnt = 16'd0;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Monitor: samples registered outputs 3ns after the edge.
    always @(posedge clock) begin
        exp_t e;
        #3;
        if (bus.wr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("wr_valid_unexpected", {31'd0, bus.wr_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e.rd});
                check("wr_data", bus.wr_data, e.data);
                check("we_vec", bus.we_vec, e.we);
                check("grant_cnt", {16'd0, bus.grant_cnt}, {16'd0, e.cnt});
            end
        end else begin
            check("we_vec_idle", bus.we_vec, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] iv;
        bus.hold = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;
        @(posedge clock);
        #1;

        // Reset then idle
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        check("rst_grant_cnt", {16'd0, bus.grant_cnt}, 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
        check("rst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);

        // Single write; data/addr must hold once wr_valid drops
        cycle(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("single_we_vec", bus.we_vec, 32'h0000_0020);
        idle();
        check("single_grant_cnt", {16'd0, bus.grant_cnt}, 32'd1);
        check("hold_wr_data", bus.wr_data, 32'hDEADBEEF);
        check("hold_wr_addr", {27'd0, bus.wr_addr}, 32'd5);

        // Contention: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22,
                  (i % 2) == 0, (i % 2) == 1);
        idle();
        check("rr_grant_cnt", {16'd0, bus.grant_cnt}, 32'd5);

        // x0: accepted and counted, no enable
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1);

        // hold blocks grants but not the x0 presentation in flight
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
        check("x0_grant_cnt", {16'd0, bus.grant_cnt}, 32'd6);

        // Accept req0 rd=7 (rr now prefers req1), then reset with valids still up
        cycle(1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
        check("midrst_we_vec", bus.we_vec, 32'd0);
        check("midrst_grant_cnt", {16'd0, bus.grant_cnt}, 32'd0);
        check("midrst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        // rr pointer must be back on requester 0
        cycle(1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        idle();

        // Counter wrap: 65536 back-to-back writes after reset
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            iv = i;
            cycle(1'b0, 1'b0, 1'b1, iv[4:0], iv, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        idle();
        check("wrap_grant_cnt", {16'd0, bus.grant_cnt}, 32'd0);
        idle();
        idle();
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
